// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the control unit and the unified memory.
// The controller is the master; the memory answers with mem_ready.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: Moore decode of the state register,
// stalling on mem_ready, with sticky illegal flag and retire counter.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [5:0]        opcode,
    input  logic              zero,
    multicycle_ctrl_if.master mem,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_we,
    output logic [3:0]        state,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_FUN = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    state_t cur;
    state_t nxt;
    logic   retire;
    logic   set_ill;
    logic   clr_ill;
    logic   is_itype;

    assign state    = cur;
    assign is_itype = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
                      (opcode == OP_ANDI) || (opcode == OP_ORI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_IDLE;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (set_ill)
                illegal <= 1'b1;
            else if (clr_ill)
                illegal <= 1'b0;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        nxt         = cur;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.iord    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_op      = ALU_ADD;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_we      = 1'b0;
        retire      = 1'b0;
        set_ill     = 1'b0;
        clr_ill     = 1'b0;

        unique case (cur)
            S_IDLE: begin
                if (run)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'd1;
                if (mem.mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                // branch target is formed here while the opcode is decoded
                alu_src_b = 2'd3;
                unique case (1'b1)
                    (opcode == OP_R):   nxt = S_EXEC_R;
                    (opcode == OP_LW),
                    (opcode == OP_SW):  nxt = S_MEM_ADDR;
                    is_itype:           nxt = S_EXEC_I;
                    (opcode == OP_BEQ): nxt = S_BRANCH;
                    (opcode == OP_J):   nxt = S_JUMP;
                    default: begin
                        nxt     = S_HALT;
                        set_ill = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                if (mem.mem_ready)
                    nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEM_WR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.iord    = 1'b1;
                if (mem.mem_ready) begin
                    retire = 1'b1;
                    nxt    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUN;
                nxt       = S_R_WB;
            end
            S_R_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
                nxt     = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                unique case (1'b1)
                    (opcode == OP_SLTI): alu_op = ALU_SLT;
                    (opcode == OP_ANDI): alu_op = ALU_AND;
                    (opcode == OP_ORI):  alu_op = ALU_OR;
                    default:             alu_op = ALU_ADD;
                endcase
                nxt = S_I_WB;
            end
            S_I_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
                nxt    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_we     = zero;
                retire    = 1'b1;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_src = 2'd2;
                pc_we  = 1'b1;
                retire = 1'b1;
                nxt    = S_FETCH;
            end
            S_HALT: begin
                if (run) begin
                    clr_ill = 1'b1;
                    nxt     = S_FETCH;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction sequence model.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       rn;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             zero;
    logic [5:0]       opcode;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_we;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;
    logic [15:0]      ctrl;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem         (bus),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_we      (reg_we),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign ctrl = {bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, pc_src,
                   alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_we};

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_SLTI,
                          OP_ANDI, OP_ORI, OP_BEQ, OP_J};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        zero = 1'b0;
        opcode = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        tests++;
        if ({state, illegal, instr_count} !== '0) begin
            fails++;
            $display("FAIL reset_state: got st=%0d ill=%0b cnt=%0d want 0/0/0",
                     state, illegal, instr_count);
        end
        tests++;
        if (ctrl !== 16'h0) begin
            fails++;
            $display("FAIL reset_ctrl: got %h want 0000", ctrl);
        end
        do_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'(i);
            #1;
            tests++;
            if (state !== 4'd0 || ctrl !== 16'h0) begin
                fails++;
                $display("FAIL idle_hold: got st=%0d ctrl=%h want 0/0000",
                         state, ctrl);
            end
        end
    endtask

    task automatic test_rtype;
        logic [3:0] es [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        do_reset;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        opcode = OP_R;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({state, reg_we, reg_dst} !==
                {es[i], es[i] == 4'd8, es[i] == 4'd8}) begin
                fails++;
                $display("FAIL rtype[%0d]: got st=%0d we=%0b dst=%0b want st=%0d",
                         i, state, reg_we, reg_dst, es[i]);
            end
        end
        tests++;
        if (instr_count !== 4'd1) begin
            fails++;
            $display("FAIL rtype_count: got %0d want 1", instr_count);
        end
    endtask

    task automatic test_lw_wait;
        logic [3:0] es [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3,
                                4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
        logic       rd [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int pulses = 0;
        logic [4:0] want;
        do_reset;
        run = 1'b1;
        opcode = OP_LW;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mem_ready = rd[i];
            run = 1'b0;
            #1;
            if (ir_we === 1'b1)
                pulses++;
            want = {es[i] == 4'd1 || es[i] == 4'd4, es[i] == 4'd4,
                    es[i] == 4'd1 && rd[i], es[i] == 4'd5, 1'b0};
            tests++;
            if (state !== es[i] ||
                {bus.mem_req, bus.iord, ir_we, mem_to_reg, bus.mem_we} !== want) begin
                fails++;
                $display("FAIL lw_wait[%0d]: got st=%0d sig=%b want st=%0d sig=%b",
                         i, state,
                         {bus.mem_req, bus.iord, ir_we, mem_to_reg, bus.mem_we},
                         es[i], want);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (state !== 4'd1 || instr_count !== 4'd1) begin
            fails++;
            $display("FAIL lw_latency: got st=%0d cnt=%0d want 1/1",
                     state, instr_count);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL lw_irwe_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_beq;
        logic [3:0] es [6] = '{4'd1, 4'd2, 4'd11, 4'd1, 4'd2, 4'd11};
        logic [5:0] want;
        logic z;
        do_reset;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        opcode = OP_BEQ;
        for (int i = 0; i < 6; i++) begin
            z = (i >= 3);
            @(negedge clk);
            zero = z;
            #1;
            want = {(es[i] == 4'd1) || (es[i] == 4'd11 && z),
                    es[i] == 4'd11 ? 2'd1 : 2'd0,
                    es[i] == 4'd11 ? 3'd1 : 3'd0};
            tests++;
            if (state !== es[i] || {pc_we, pc_src, alu_op} !== want) begin
                fails++;
                $display("FAIL beq[%0d]: got st=%0d sig=%b want st=%0d sig=%b",
                         i, state, {pc_we, pc_src, alu_op}, es[i], want);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (state !== 4'd1 || instr_count !== 4'd2) begin
            fails++;
            $display("FAIL beq_count: got st=%0d cnt=%0d want 1/2",
                     state, instr_count);
        end
    endtask

    task automatic test_sw_j;
        logic [3:0] es [7] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd1, 4'd2, 4'd12};
        logic [5:0] want;
        do_reset;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            opcode = (i < 4) ? OP_SW : OP_J;
            #1;
            want = {es[i] == 4'd6, es[i] == 4'd6, 1'b0,
                    es[i] == 4'd1 || es[i] == 4'd12,
                    es[i] == 4'd12 ? 2'd2 : 2'd0};
            tests++;
            if (state !== es[i] ||
                {bus.mem_we, bus.iord, reg_we, pc_we, pc_src} !== want) begin
                fails++;
                $display("FAIL sw_j[%0d]: got st=%0d sig=%b want st=%0d sig=%b",
                         i, state, {bus.mem_we, bus.iord, reg_we, pc_we, pc_src},
                         es[i], want);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (state !== 4'd1 || instr_count !== 4'd2) begin
            fails++;
            $display("FAIL sw_j_count: got st=%0d cnt=%0d want 1/2",
                     state, instr_count);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] es [5] = '{4'd1, 4'd2, 4'd13, 4'd13, 4'd13};
        logic       rn [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        opcode = 6'b111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run = rn[i];
            #1;
            tests++;
            if (state !== es[i] || illegal !== (es[i] == 4'd13) ||
                (es[i] == 4'd13 && ctrl !== 16'h0)) begin
                fails++;
                $display("FAIL illegal[%0d]: got st=%0d ill=%0b ctrl=%h want st=%0d",
                         i, state, illegal, ctrl, es[i]);
            end
        end
        @(negedge clk);
        run = 1'b0;
        #1;
        tests++;
        if ({state, illegal, instr_count} !== {4'd1, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL illegal_exit: got st=%0d ill=%0b cnt=%0d want 1/0/0",
                     state, illegal, instr_count);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] es [9] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1,
                               4'd2, 4'd3, 4'd4, 4'd4};
        logic       rd [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b0};
        do_reset;
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            opcode = (i < 4) ? OP_R : OP_LW;
            bus.mem_ready = rd[i];
            #1;
            tests++;
            if (state !== es[i]) begin
                fails++;
                $display("FAIL reset_mid_seq[%0d]: got %0d want %0d",
                         i, state, es[i]);
            end
        end
        tests++;
        if (instr_count !== 4'd1 || bus.mem_req !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre: got cnt=%0d req=%0b want 1/1",
                     instr_count, bus.mem_req);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({state, instr_count, illegal} !== '0 || ctrl !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid: got st=%0d cnt=%0d ctrl=%h want 0/0/0000",
                     state, instr_count, ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b0;
    endtask

    task automatic test_wrap;
        do_reset;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        opcode = OP_J;
        @(negedge clk);
        for (int n = 1; n <= 16; n++) begin
            repeat (3) @(negedge clk);
            #1;
            tests++;
            if (state !== 4'd1 || instr_count !== 4'(n)) begin
                fails++;
                $display("FAIL wrap[%0d]: got st=%0d cnt=%0d want 1/%0d",
                         n, state, instr_count, n % 16);
            end
        end
    endtask

    task automatic test_random;
        item_t q[$];
        int retired = 0;
        int cls, fw, mw, hk;
        logic [5:0] op;
        logic z;
        logic [2:0] ialu;
        logic [2:0] ealu;
        logic [21:0] got;
        logic [21:0] want;
        item_t it;
        do_reset;
        run = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 9);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            hk = $urandom_range(0, 2);
            z = 1'($urandom_range(0, 1));
            ialu = 3'd0;
            case (cls)
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_ADDI;
                4: begin op = OP_SLTI; ialu = 3'd5; end
                5: begin op = OP_ANDI; ialu = 3'd3; end
                6: begin op = OP_ORI;  ialu = 3'd4; end
                7: op = OP_BEQ;
                8: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op))
                        op = 6'($urandom);
                end
            endcase
            q.delete();
            for (int k = 0; k < fw; k++)
                q.push_back('{4'd1, 1'b0, 1'($urandom)});
            q.push_back('{4'd1, 1'b1, 1'($urandom)});
            q.push_back('{4'd2, 1'($urandom), 1'($urandom)});
            case (cls)
                0: begin
                    q.push_back('{4'd7, 1'($urandom), 1'($urandom)});
                    q.push_back('{4'd8, 1'($urandom), 1'($urandom)});
                end
                1: begin
                    q.push_back('{4'd3, 1'($urandom), 1'($urandom)});
                    for (int k = 0; k < mw; k++)
                        q.push_back('{4'd4, 1'b0, 1'($urandom)});
                    q.push_back('{4'd4, 1'b1, 1'($urandom)});
                    q.push_back('{4'd5, 1'($urandom), 1'($urandom)});
                end
                2: begin
                    q.push_back('{4'd3, 1'($urandom), 1'($urandom)});
                    for (int k = 0; k < mw; k++)
                        q.push_back('{4'd6, 1'b0, 1'($urandom)});
                    q.push_back('{4'd6, 1'b1, 1'($urandom)});
                end
                3, 4, 5, 6: begin
                    q.push_back('{4'd9, 1'($urandom), 1'($urandom)});
                    q.push_back('{4'd10, 1'($urandom), 1'($urandom)});
                end
                7: q.push_back('{4'd11, 1'($urandom), 1'($urandom)});
                8: q.push_back('{4'd12, 1'($urandom), 1'($urandom)});
                default: begin
                    for (int k = 0; k < hk; k++)
                        q.push_back('{4'd13, 1'($urandom), 1'b0});
                    q.push_back('{4'd13, 1'($urandom), 1'b1});
                end
            endcase
            foreach (q[i]) begin
                it = q[i];
                @(negedge clk);
                opcode = op;
                zero = z;
                bus.mem_ready = it.rdy;
                run = it.rn;
                #1;
                ealu = (it.st == 4'd7)  ? 3'd2 :
                       (it.st == 4'd11) ? 3'd1 :
                       (it.st == 4'd9)  ? ialu : 3'd0;
                want = {it.st,
                        it.st inside {4'd1, 4'd4, 4'd6},
                        it.st == 4'd6,
                        it.st inside {4'd4, 4'd6},
                        it.st == 4'd1 && it.rdy,
                        (it.st == 4'd1 && it.rdy) || it.st == 4'd12 ||
                        (it.st == 4'd11 && z),
                        it.st == 4'd11 ? 2'd1 : (it.st == 4'd12 ? 2'd2 : 2'd0),
                        it.st inside {4'd5, 4'd8, 4'd10},
                        it.st == 4'd8,
                        it.st == 4'd5,
                        ealu,
                        it.st == 4'd13,
                        4'(retired)};
                got = {state, bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we,
                       pc_src, reg_we, reg_dst, mem_to_reg, alu_op, illegal,
                       instr_count};
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL random[%0d.%0d] op=%b: got %h want %h",
                             n, i, op, got, want);
                end
            end
            if (cls != 9)
                retired++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        zero = 1'b0;
        opcode = '0;
        bus.mem_ready = 1'b0;
        test_reset;
        test_rtype;
        test_lw_wait;
        test_beq;
        test_sw_j;
        test_illegal;
        test_reset_mid;
        test_wrap;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit sequencing the MIPS-subset datapath (PC, instruction register, register file, ALU, unified memory port) through fetch/decode/execute/memory/writeback. It decodes the latched opcode, drives every datapath enable and mux select as a Moore function of its state, and stalls on a ready/request handshake with the memory port. It also reports the current state, an illegal-opcode flag and a retired-instruction counter for the testbench.

## Interface
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  leave IDLE and start fetching; sampled only in IDLE and HALT.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag, valid in BRANCH.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write (1) / read (0) qualifier for mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out.
- ir_we  out  1  load instruction register.
- pc_we  out  1  load PC.
- pc_src  out  2  0 = ALU result, 1 = ALU out register (branch target), 2 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = register B, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm << 2.
- alu_op  out  3  0 add, 1 sub, 2 funct-decoded, 3 and, 4 or, 5 slt.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALU out, 1 = memory data register.
- reg_we  out  1  register file write.
- state  out  4  current state encoding (below).
- illegal  out  1  sticky, set on unsupported opcode.
- instr_count  out  CNT_W  retired instructions.

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, R_WB 8, EXEC_I 9, I_WB 10, BRANCH 11, JUMP 12, HALT 13.
- Reset (async): state=IDLE, illegal=0, instr_count=0; all control outputs 0 in IDLE and HALT.
- IDLE: run=1 -> FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0; ir_we and pc_we asserted only in the cycle mem_ready=1, then -> DECODE; else stay.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target precomputed). Dispatch on opcode: 000000 -> EXEC_R; 100011 lw / 101011 sw -> MEM_ADDR; 001000 addi, 001010 slti, 001100 andi, 001101 ori -> EXEC_I; 000100 beq -> BRANCH; 000010 j -> JUMP; other -> HALT with illegal set.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1, mem_we=0; on mem_ready -> MEM_WB. MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> R_WB: reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op = add/slt/and/or per opcode -> I_WB: reg_we=1, reg_dst=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=1, pc_we=zero -> FETCH.
- JUMP: pc_src=2, pc_we=1 -> FETCH.
- HALT: run=1 -> FETCH with illegal cleared; else stay.
- instr_count increments (wrap modulo 2^CNT_W) on every transition into FETCH from a final state (MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP); not from IDLE/HALT.
- Opcode is sampled only in DECODE and MEM_ADDR/EXEC_I; IR holds it stable.

## Timing
- Outputs are combinational decode of the state register only (except pc_we/ir_we gated by mem_ready in FETCH, pc_we gated by zero in BRANCH, mem-state exit on mem_ready).
- Cycles per instruction at zero wait (mem_ready held 1): R 4, addi/slti/andi/ori 4, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds exactly 1.
- mem_req stays high and address/mem_we stable until the mem_ready cycle; mem_req drops the cycle after.
- rst_n low mid-instruction: immediate IDLE, outputs 0, no partial register or memory write after reset asserts.
- mem_ready outside memory states: ignored.

## Test plan
- Reset then run=1, mem_ready=1, opcode=000000: state 0->1->2->7->8->1; reg_we=1 only in state 8 with reg_dst=1; instr_count=1.
- lw (100011) with mem_ready low 2 cycles in FETCH and 3 in MEM_RD: 10 cycles from FETCH entry to next FETCH; ir_we single pulse; mem_to_reg=1 in MEM_WB.
- beq with zero=0 then zero=1: pc_we=0 then 1 in BRANCH, pc_src=1; each 3 cycles; count +2.
- sw then j: mem_we=1 with iord=1 only in MEM_WR; JUMP asserts pc_we=1, pc_src=2; reg_we never asserted.
- opcode 111111: DECODE -> HALT, illegal=1, count unchanged; run=1 -> FETCH, illegal=0.
- rst_n low during MEM_RD wait: state=0, mem_req=0 same cycle, instr_count=0; preload instr_count near 2^CNT_W-1 (CNT_W=4, 15 instructions then 1 more) -> wraps to 0.
